// File: rtl/unlock_entry_ctrl.sv
// Keypad entry sequencer for the unlocker: buffers 4 username + 4 password nibbles and tracks failed logins.
// Optional timed lockout after repeated failures is built when LOCKOUT_EN is defined.
module unlock_entry_ctrl #(
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int CNT_W          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        digit_valid,
    input  logic [3:0]  digit_val,
    input  logic        btn_back,
    input  logic        btn_clear,
    input  logic        reset_count,
    input  logic        flag,
    input  logic        lock,
    output logic [3:0]  input_count,
    output logic [15:0] user_name,
    output logic [15:0] password,
    output logic        flag_resolve,
    output logic [3:0]  fail_count,
    output logic        lockout
);

    if (MAX_FAILS < 1 || MAX_FAILS > 15 || CNT_W < 1 || CNT_W > 30 ||
        LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES >= (1 << CNT_W)) begin : g_param_check
        $error("unlock_entry_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {S_ENTRY, S_FULL, S_LOCKOUT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] entry_q, entry_d;   // {password, user_name}, nibble k at [4k+:4]
    logic [3:0]  fail_q, fail_d;
    logic        fr_q, fr_d;
    logic        rc_q, fl_q, lk_q;
    logic        rc_rise, fl_rise, unlk, trip;
    logic [3:0]  fail_inc, back_idx;

    assign rc_rise  = reset_count & ~rc_q;
    assign fl_rise  = flag & ~fl_q;
    assign unlk     = ~lock & lk_q;
    assign fail_inc = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
    assign back_idx = count_q - 4'd1;

`ifdef LOCKOUT_EN
    logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
    logic             lockout_q;
    logic             lo_done;

    assign trip    = lock & (fail_inc >= 4'(MAX_FAILS));
    assign lo_done = (lo_cnt_q == '0);
    assign lockout = lockout_q;
`else
    assign trip    = 1'b0;
    assign lockout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_ENTRY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_LOCKOUT) begin
`ifdef LOCKOUT_EN
            if (lo_done) state_d = S_ENTRY;
`endif
        end else if (rc_rise) begin
            state_d = S_ENTRY;
        end else if (fl_rise) begin
            state_d = trip ? S_LOCKOUT : S_ENTRY;
        end else if (btn_clear || btn_back) begin
            state_d = S_ENTRY;
        end else if (digit_valid && state_q == S_ENTRY && count_q == 4'd7) begin
            state_d = S_FULL;
        end
    end

    always_comb begin
        count_d = count_q;
        entry_d = entry_q;
        fail_d  = fail_q;
        fr_d    = 1'b0;
`ifdef LOCKOUT_EN
        lo_cnt_d = lo_cnt_q;
`endif
        if (state_q == S_LOCKOUT) begin
            // buffers are already empty here; only failure counting and the timer run
            if (fl_rise && lock) fail_d = fail_inc;
`ifdef LOCKOUT_EN
            if (lo_done) begin
                fail_d = '0;
                fr_d   = ~fr_q;
            end else begin
                lo_cnt_d = lo_cnt_q - CNT_W'(1);
            end
`endif
        end else if (rc_rise) begin
            count_d = '0;
            entry_d = '0;
        end else if (fl_rise) begin
            count_d = '0;
            entry_d = '0;
            if (lock) fail_d = fail_inc;
`ifdef LOCKOUT_EN
            if (trip) lo_cnt_d = CNT_W'(LOCKOUT_CYCLES - 1);
`endif
        end else if (btn_clear) begin
            count_d = '0;
            entry_d = '0;
            fr_d    = flag & ~fr_q;
        end else if (btn_back) begin
            if (count_q != 4'd0) begin
                count_d = back_idx;
                entry_d[{back_idx[2:0], 2'b00} +: 4] = 4'd0;
            end
        end else if (digit_valid && state_q == S_ENTRY) begin
            entry_d[{count_q[2:0], 2'b00} +: 4] = digit_val;
            count_d = count_q + 4'd1;
        end
        if (unlk) fail_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            entry_q <= '0;
            fail_q  <= '0;
            fr_q    <= 1'b0;
            rc_q    <= 1'b0;
            fl_q    <= 1'b0;
            lk_q    <= 1'b1;
        end else begin
            count_q <= count_d;
            entry_q <= entry_d;
            fail_q  <= fail_d;
            fr_q    <= fr_d;
            rc_q    <= reset_count;
            fl_q    <= flag;
            lk_q    <= lock;
        end
    end

`ifdef LOCKOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_cnt_q  <= '0;
            lockout_q <= 1'b0;
        end else begin
            lo_cnt_q  <= lo_cnt_d;
            lockout_q <= (state_d == S_LOCKOUT);
        end
    end
`endif

    assign input_count  = count_q;
    assign user_name    = entry_q[15:0];
    assign password     = entry_q[31:16];
    assign flag_resolve = fr_q;
    assign fail_count   = fail_q;

endmodule

// File: tb/tb_unlock_entry_ctrl.sv
// Randomized + directed bench for unlock_entry_ctrl; a queue-of-digits reference model feeds a scoreboard.
module tb_unlock_entry_ctrl;
    localparam int MAXF = 3;
    localparam int LCYC = 10;
`ifdef LOCKOUT_EN
    localparam bit LO_EN = 1'b1;
`else
    localparam bit LO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit_val = 4'd0;
    logic        btn_back = 1'b0;
    logic        btn_clear = 1'b0;
    logic        reset_count = 1'b0;
    logic        flag = 1'b0;
    logic        lock = 1'b1;
    logic [3:0]  input_count;
    logic [15:0] user_name;
    logic [15:0] password;
    logic        flag_resolve;
    logic [3:0]  fail_count;
    logic        lockout;

    unlock_entry_ctrl #(.MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LCYC), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit_val(digit_val),
        .btn_back(btn_back), .btn_clear(btn_clear), .reset_count(reset_count),
        .flag(flag), .lock(lock), .input_count(input_count), .user_name(user_name),
        .password(password), .flag_resolve(flag_resolve), .fail_count(fail_count),
        .lockout(lockout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cnt;
        logic [15:0] un;
        logic [15:0] pw;
        logic        fr;
        logic [3:0]  fc;
        logic        lo;
    } exp_t;

    exp_t expq[$];
    int checks = 0;
    int errors = 0;

    // reference model: entry as a list of digits, failures as an integer
    logic [3:0] m_digits[$];
    int m_fails = 0;
    bit m_lo = 0;
    int m_rem = 0;
    bit m_fr = 0;
    bit p_rc = 0, p_fl = 0, p_lk = 1;

    logic rc_l = 1'b0, fl_l = 1'b0, lk_l = 1'b1;

    task automatic model_step(input bit r, input bit dv, input bit [3:0] d, input bit bk,
                              input bit cl, input bit rc, input bit fl, input bit lk);
        bit rcr, flr, unl, nfr;
        exp_t e;
        nfr = 1'b0;
        if (r) begin
            m_digits.delete();
            m_fails = 0; m_lo = 0; m_rem = 0;
            p_rc = 0; p_fl = 0; p_lk = 1;
        end else begin
            rcr = rc && !p_rc;
            flr = fl && !p_fl;
            unl = !lk && p_lk;
            if (m_lo) begin
                if (flr && lk) m_fails = (m_fails < 15) ? m_fails + 1 : 15;
                if (m_rem == 0) begin
                    m_lo = 0; m_fails = 0; nfr = !m_fr;
                end else m_rem--;
            end else if (rcr) begin
                m_digits.delete();
            end else if (flr) begin
                m_digits.delete();
                if (lk) begin
                    m_fails = (m_fails < 15) ? m_fails + 1 : 15;
                    if (LO_EN && m_fails >= MAXF) begin
                        m_lo = 1; m_rem = LCYC - 1;
                    end
                end
            end else if (cl) begin
                m_digits.delete();
                nfr = fl && !m_fr;
            end else if (bk) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
            end else if (dv && m_digits.size() < 8) begin
                m_digits.push_back(d);
            end
            if (unl) m_fails = 0;
            p_rc = rc; p_fl = fl; p_lk = lk;
        end
        m_fr = nfr;
        e.un = 16'h0; e.pw = 16'h0;
        for (int i = 0; i < m_digits.size(); i++) begin
            if (i < 4) e.un[4*i +: 4] = m_digits[i];
            else       e.pw[4*(i-4) +: 4] = m_digits[i];
        end
        e.cnt = 4'(m_digits.size());
        e.fr  = m_fr;
        e.fc  = 4'(m_fails);
        e.lo  = m_lo;
        expq.push_back(e);
    endtask

    task automatic tick(input bit r, input bit dv, input bit [3:0] d, input bit bk, input bit cl);
        @(negedge clk);
        rst = r; digit_valid = dv; digit_val = d; btn_back = bk; btn_clear = cl;
        reset_count = rc_l; flag = fl_l; lock = lk_l;
        model_step(r, dv, d, bk, cl, rc_l, fl_l, lk_l);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 4'd0, 0, 0);
    endtask

    task automatic dig(input bit [3:0] v);
        tick(0, 1, v, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: the DUT presents a fresh output set after every clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("input_count",  32'(input_count),  32'(e.cnt));
                chk("user_name",    32'(user_name),    32'(e.un));
                chk("password",     32'(password),     32'(e.pw));
                chk("flag_resolve", 32'(flag_resolve), 32'(e.fr));
                chk("fail_count",   32'(fail_count),   32'(e.fc));
                chk("lockout",      32'(lockout),      32'(e.lo));
            end
        end
    end

    initial begin
        bit [3:0] t1[8] = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0};
        // T1: reset, fill eight digits, ninth is ignored
        tick(1, 0, 4'd0, 0, 0);
        tick(1, 0, 4'd0, 0, 0);
        foreach (t1[i]) dig(t1[i]);
        dig(4'd5);
        idle(1);
        // T2: three digits, back once, then back past empty
        tick(0, 0, 4'd0, 0, 1);
        dig(4'd5); dig(4'd6); dig(4'd7);
        tick(0, 0, 4'd0, 1, 0);
        idle(1);
        repeat (3) tick(0, 0, 4'd0, 1, 0);
        idle(1);
        // T3: full entry, reset_count held high for four cycles clears once
        for (int i = 0; i < 8; i++) dig(4'(i + 8));
        rc_l = 1'b1;
        repeat (4) dig(4'd9);
        rc_l = 1'b0;
        dig(4'd3);
        idle(1);
        // T4: failed login, then acknowledge with clear
        lk_l = 1'b1; fl_l = 1'b1;
        idle(2);
        tick(0, 0, 4'd0, 0, 1);
        tick(0, 0, 4'd0, 0, 1);
        idle(2);
        fl_l = 1'b0;
        idle(1);
        // T5: three failures from a clean start, digits during (possible) lockout
        tick(1, 0, 4'd0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            fl_l = 1'b1; idle(1);
            fl_l = 1'b0; idle(1);
        end
        for (int i = 0; i < LCYC + 4; i++) tick(0, 1, 4'(i), i % 5 == 4, i % 7 == 6);
        idle(3);
        // T6: digit, back and reset_count edge together; then unlock clears failures
        dig(4'd2); dig(4'd4); dig(4'd6);
        rc_l = 1'b1;
        tick(0, 1, 4'd7, 1, 0);
        rc_l = 1'b0;
        idle(1);
        lk_l = 1'b0;
        idle(2);
        lk_l = 1'b1;
        idle(1);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) rc_l = ~rc_l;
            if ($urandom_range(0, 11) == 0) fl_l = ~fl_l;
            if ($urandom_range(0, 23) == 0) lk_l = ~lk_l;
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 11) == 0);
        end
        idle(1);
        for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk);
        #2;
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
